multi_atomic_counter: RTL and testbench
=======================================

# multi_atomic_counter

Parametrised, multi-channel successor of the single 64-bit atomic counter: NUM_CH independent event counters of CNT_W bits, each read over a narrower RD_W-bit bus. An atomic read returns one live word and snapshots the whole counter of the selected channel into a per-channel shadow register, so later non-atomic reads return coherent remaining words. Adds per-channel clear, selectable wrap/saturate mode and sticky overflow flags. Sits between event sources (trig) and the register-read interface (req/ack).

## Interface
- NUM_CH, 4: number of counter channels (≥1)
- CNT_W, 64: counter width; must be an integer multiple of RD_W
- RD_W, 32: read data width; NWORDS = CNT_W/RD_W
- SAT, 0: 0 = wrap at all-ones, 1 = saturate at all-ones
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled only on rising clk
- trig  in  NUM_CH  per-channel increment-by-1 request
- clr  in  NUM_CH  per-channel synchronous clear of counter and ovf
- req  in  1  read request, one read per asserted cycle
- atomic  in  1  qualifies req: 1 = live read + snapshot, 0 = shadow read
- sel  in  max(1,$clog2(NUM_CH))  channel index, qualified by req
- word  in  max(1,$clog2(NWORDS))  word index (0 = LS word), qualified by req
- ack  out  1  read response valid
- count  out  RD_W  read data; 0 whenever ack = 0
- ovf  out  NUM_CH  sticky overflow/saturation flag per channel

## Operation
- Reset (reset = 0 at an edge): all counters, shadows, ovf, ack, count cleared to 0; overrides all other inputs that cycle.
- Counter i per edge, priority: clr[i] → 0; else trig[i] → +1 (SAT=0: all-ones+1 = 0; SAT=1: all-ones holds); else hold.
- ovf[i]: set at the edge where counter i wraps (SAT=0) or where trig[i] arrives while counter i is all-ones (SAT=1); cleared only by clr[i] or reset; clr[i] wins over a same-cycle set.
- Read, req = 1 at cycle t, sel = s, word = w:
  - atomic = 1: count = word w of counter s value in cycle t (pre-edge, excludes trig at t); shadow[s] ← full counter s value in cycle t.
  - atomic = 0: count = word w of shadow[s] value in cycle t (includes a snapshot written at the edge ending cycle t-1).
- Out-of-range: sel ≥ NUM_CH or w ≥ NWORDS → ack still asserted, count = 0, no shadow write.
- Snapshot is independent of clr: atomic read with clr[s] in same cycle captures pre-clear value.
- Shadows hold until next atomic read of same channel; clr does not alter shadow.
- Typical coherent 64-bit read: atomic read word 0, then non-atomic read word 1.

## Timing
- Latency 1: req at cycle t → ack = 1 and count valid in cycle t+1, both registered.
- No back-pressure; req may be asserted every cycle; each request gets exactly one ack cycle.
- Back-to-back atomic (t) then non-atomic same channel (t+1): second read returns snapshot taken at t.
- ack = 0 → count = 0 (registered to 0, not gated combinationally).
- Reset asserted mid-read: ack/count 0 on the following cycle; pending response dropped.
- Counter update and read path operate in parallel; trig never stalls.

## Test plan
- Reset: hold reset = 0 two cycles with trig/req active → ack = 0, count = 0, ovf = 0; after release, 10 trig[1] pulses, atomic read sel=1 word=0 → ack next cycle, count = 10.
- Coherence (CNT_W=64, RD_W=32): preload ch0 to 0x0000_0000_FFFF_FFFF by trig, atomic read word 0 → 0xFFFF_FFFF; trig ch0 every cycle; non-atomic read word 1 → 0x0000_0000 despite live MSW now 1.
- Wrap vs saturate: ch2 at all-ones, trig → SAT=0: counter 0, ovf[2] = 1; SAT=1: stays all-ones, ovf[2] = 1; clr[2] → counter 0, ovf[2] = 0.
- Simultaneous clr+trig+atomic read on ch3 at value 5 → count = 5, shadow = 5, counter = 0 next cycle, non-atomic read word 0 → 5.
- Channel isolation / back-to-back: atomic reads ch0 then ch1 on consecutive cycles, trig only ch1 → ch0 shadow unchanged, each req yields one ack cycle, correct per-channel values.
- Out-of-range: NUM_CH=3, sel = 3 → ack = 1, count = 0, no shadow change; word = 2 with NWORDS=2 → count = 0.

Source files
------------

// File: rtl/multi_atomic_counter.sv
// Multi-channel event counters read over a narrow bus; an atomic read snapshots
// the whole selected counter into a per-channel shadow for coherent multi-word reads.
module multi_atomic_counter #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 64,
  parameter int RD_W   = 32,
  parameter int SAT    = 0,
  localparam int NWORDS = CNT_W / RD_W,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WORD_W = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] trig,
  input  logic [NUM_CH-1:0] clr,
  input  logic              req,
  input  logic              atomic,
  input  logic [SEL_W-1:0]  sel,
  input  logic [WORD_W-1:0] word,
  output logic              ack,
  output logic [RD_W-1:0]   count,
  output logic [NUM_CH-1:0] ovf
);

  logic [CNT_W-1:0] cnt_q    [NUM_CH];
  logic [CNT_W-1:0] shadow_q [NUM_CH];

  logic [CNT_W-1:0] rd_val;
  logic [RD_W-1:0]  rd_word;
  logic             sel_hit;
  logic             word_hit;
  logic             rd_ok;

  // Out-of-range sel/word simply never match, leaving the read data at zero.
  always_comb begin
    rd_val   = '0;
    rd_word  = '0;
    sel_hit  = 1'b0;
    word_hit = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (sel == SEL_W'(c)) begin
        sel_hit = 1'b1;
        rd_val  = atomic ? cnt_q[c] : shadow_q[c];
      end
    end
    for (int unsigned w = 0; w < NWORDS; w++) begin
      if (word == WORD_W'(w)) begin
        word_hit = 1'b1;
        rd_word  = rd_val[w*RD_W +: RD_W];
      end
    end
    rd_ok = req & sel_hit & word_hit;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cnt_q[c]    <= '0;
        shadow_q[c] <= '0;
      end
      ovf   <= '0;
      ack   <= 1'b0;
      count <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (clr[c]) begin
          cnt_q[c] <= '0;
          ovf[c]   <= 1'b0;
        end else if (trig[c]) begin
          if (&cnt_q[c]) begin
            ovf[c] <= 1'b1;
            if (SAT == 0) cnt_q[c] <= '0;
          end else begin
            cnt_q[c] <= cnt_q[c] + CNT_W'(1);
          end
        end
        // Snapshot takes the pre-edge value, so a same-cycle clr is not seen.
        if (rd_ok && atomic && sel == SEL_W'(c)) shadow_q[c] <= cnt_q[c];
      end
      ack   <= req;
      count <= rd_ok ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_multi_atomic_counter.sv
// Bench for multi_atomic_counter: wrap and saturate instances driven in lockstep
// against an integer-level reference model of counters, shadows and flags.
module tb_multi_atomic_counter;
  localparam int NCH = 3;
  localparam int CW  = 12;
  localparam int RW  = 4;
  localparam int NW  = 3;
  localparam int unsigned MAXV = 4095;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] trig = '0;
  logic [2:0] clr = '0;
  logic       req = 1'b0;
  logic       atomic = 1'b0;
  logic [1:0] sel = '0;
  logic [1:0] word = '0;
  logic       ack_o [2];
  logic [3:0] cnt_o [2];
  logic [2:0] ovf_o [2];

  multi_atomic_counter #(.NUM_CH(NCH), .CNT_W(CW), .RD_W(RW), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .trig(trig), .clr(clr), .req(req), .atomic(atomic),
    .sel(sel), .word(word), .ack(ack_o[0]), .count(cnt_o[0]), .ovf(ovf_o[0]));

  multi_atomic_counter #(.NUM_CH(NCH), .CNT_W(CW), .RD_W(RW), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .trig(trig), .clr(clr), .req(req), .atomic(atomic),
    .sel(sel), .word(word), .ack(ack_o[1]), .count(cnt_o[1]), .ovf(ovf_o[1]));

  always #5 clk = ~clk;

  // Reference state: index 0 = wrap instance, 1 = saturate instance.
  int unsigned m_cnt [2][NCH];
  int unsigned m_sh  [2][NCH];
  bit          m_ovf [2][NCH];
  bit          e_ack;
  int unsigned e_cnt [2];
  int          n_checks = 0;
  int          n_errs = 0;

  function automatic logic [2:0] e_ovf(int k);
    return {m_ovf[k][2], m_ovf[k][1], m_ovf[k][0]};
  endfunction

  task automatic tick();
    int unsigned src;
    for (int k = 0; k < 2; k++) begin
      e_cnt[k] = 0;
      if (!reset) begin
        e_ack = 1'b0;
        for (int c = 0; c < NCH; c++) begin
          m_cnt[k][c] = 0; m_sh[k][c] = 0; m_ovf[k][c] = 1'b0;
        end
      end else begin
        e_ack = req;
        if (req && sel < NCH && word < NW) begin
          src = atomic ? m_cnt[k][sel] : m_sh[k][sel];
          e_cnt[k] = (src >> (RW * word)) % 16;
          if (atomic) m_sh[k][sel] = m_cnt[k][sel];
        end
        for (int c = 0; c < NCH; c++) begin
          if (clr[c]) begin
            m_cnt[k][c] = 0; m_ovf[k][c] = 1'b0;
          end else if (trig[c]) begin
            if (m_cnt[k][c] == MAXV) begin
              m_ovf[k][c] = 1'b1;
              if (k == 0) m_cnt[k][c] = 0;
            end else begin
              m_cnt[k][c] = m_cnt[k][c] + 1;
            end
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; trig = 3'b111; req = 1'b1; atomic = 1'b1; sel = 2'd1; word = 2'd0;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (ack_o[k] !== 1'b0 || cnt_o[k] !== 4'h0 || ovf_o[k] !== 3'b000) begin
        n_errs++;
        $display("FAIL reset dut%0d: ack=%b count=%h ovf=%b, expected 0 0 000", k, ack_o[k], cnt_o[k], ovf_o[k]);
      end
    end
    reset = 1'b1; req = 1'b0; trig = 3'b010;
    repeat (10) tick();
    trig = '0; req = 1'b1; atomic = 1'b1; sel = 2'd1; word = 2'd0;
    tick();
    req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (ack_o[k] !== 1'b1 || cnt_o[k] !== 4'hA || cnt_o[k] !== 4'(e_cnt[k])) begin
        n_errs++;
        $display("FAIL post_reset_read dut%0d: ack=%b count=%h, expected ack=1 count=a", k, ack_o[k], cnt_o[k]);
      end
    end
  endtask

  task automatic test_coherence();
    logic [3:0] want [3];
    want[0] = 4'hF; want[1] = 4'h0; want[2] = 4'hF;
    clr = 3'b111; tick(); clr = '0;
    trig = 3'b001;
    repeat (15) tick();
    // Counter 0x00F: atomic LS read, then shadow reads while the live MSW moves on.
    req = 1'b1; atomic = 1'b1; sel = 2'd0; word = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (ack_o[k] !== 1'b1 || cnt_o[k] !== want[i] || cnt_o[k] !== 4'(e_cnt[k])) begin
          n_errs++;
          $display("FAIL coherence%0d dut%0d: ack=%b count=%h, expected ack=1 count=%h", i, k, ack_o[k], cnt_o[k], want[i]);
        end
      end
      atomic = 1'b0;
      word = (i == 0) ? 2'd1 : 2'd0;
    end
    req = 1'b0; trig = '0;
    tick();
  endtask

  task automatic test_wrap_sat();
    logic [3:0] want_ls [2];
    want_ls[0] = 4'h0; want_ls[1] = 4'hF;
    clr = 3'b100; tick(); clr = '0;
    trig = 3'b100;
    repeat (4095) tick();
    trig = 3'b000; req = 1'b1; atomic = 1'b1; sel = 2'd2; word = 2'd2;
    tick();
    req = 1'b0; trig = 3'b100;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (cnt_o[k] !== 4'hF || ovf_o[k][2] !== 1'b0) begin
        n_errs++;
        $display("FAIL all_ones dut%0d: count=%h ovf2=%b, expected count=f ovf2=0", k, cnt_o[k], ovf_o[k][2]);
      end
    end
    tick();
    trig = '0; req = 1'b1; atomic = 1'b1; sel = 2'd2; word = 2'd0;
    tick();
    req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (ovf_o[k][2] !== 1'b1 || cnt_o[k] !== want_ls[k] || ovf_o[k] !== e_ovf(k)) begin
        n_errs++;
        $display("FAIL overflow dut%0d: count=%h ovf=%b, expected count=%h ovf2=1", k, cnt_o[k], ovf_o[k], want_ls[k]);
      end
    end
    // The saturating instance is still all-ones, so this trig would set ovf; clr must win.
    clr = 3'b100; trig = 3'b100;
    tick();
    clr = '0; trig = '0; req = 1'b1; atomic = 1'b1; sel = 2'd2; word = 2'd0;
    tick();
    req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (ovf_o[k][2] !== 1'b0 || cnt_o[k] !== 4'h0) begin
        n_errs++;
        $display("FAIL clear_ovf dut%0d: count=%h ovf2=%b, expected count=0 ovf2=0", k, cnt_o[k], ovf_o[k][2]);
      end
    end
  endtask

  task automatic test_clr_trig_read();
    logic [3:0] want [3];
    want[0] = 4'h5; want[1] = 4'h5; want[2] = 4'h0;
    clr = 3'b010; tick(); clr = '0;
    trig = 3'b010;
    repeat (5) tick();
    clr = 3'b010; req = 1'b1; atomic = 1'b1; sel = 2'd1; word = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      clr = '0; trig = '0;
      atomic = (i == 1);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (ack_o[k] !== 1'b1 || cnt_o[k] !== want[i] || cnt_o[k] !== 4'(e_cnt[k])) begin
          n_errs++;
          $display("FAIL clr_trig_read%0d dut%0d: count=%h, expected %h", i, k, cnt_o[k], want[i]);
        end
      end
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    req = 1'b1; atomic = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sel = 2'(i % 2);
      word = 2'($urandom_range(0, 2));
      trig = {1'b0, 1'($urandom), 1'b0};
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (ack_o[k] !== 1'b1 || cnt_o[k] !== 4'(e_cnt[k]) || ovf_o[k] !== e_ovf(k)) begin
          n_errs++;
          $display("FAIL back_to_back%0d dut%0d: ack=%b count=%h, expected ack=1 count=%h", i, k, ack_o[k], cnt_o[k], 4'(e_cnt[k]));
        end
      end
    end
    trig = '0; atomic = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sel = 2'(i / 3);
      word = 2'(i % 3);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (ack_o[k] !== 1'b1 || cnt_o[k] !== 4'(e_cnt[k])) begin
          n_errs++;
          $display("FAIL shadow_read%0d dut%0d: count=%h, expected %h", i, k, cnt_o[k], 4'(e_cnt[k]));
        end
      end
    end
    req = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (ack_o[k] !== 1'b0 || cnt_o[k] !== 4'h0) begin
        n_errs++;
        $display("FAIL idle dut%0d: ack=%b count=%h, expected ack=0 count=0", k, ack_o[k], cnt_o[k]);
      end
    end
  endtask

  task automatic test_out_of_range();
    req = 1'b1; atomic = 1'b1; sel = 2'd0; word = 2'd0;
    tick();
    req = 1'b0; trig = 3'b001;
    repeat (5) tick();
    trig = '0; req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel  = (i == 0) ? 2'd3 : 2'd0;
      word = (i == 1) ? 2'd3 : 2'd0;
      atomic = (i != 2);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (ack_o[k] !== 1'b1 || cnt_o[k] !== 4'(e_cnt[k]) || (i < 2 && cnt_o[k] !== 4'h0)) begin
          n_errs++;
          $display("FAIL out_of_range%0d dut%0d: ack=%b count=%h, expected ack=1 count=%h", i, k, ack_o[k], cnt_o[k], 4'(e_cnt[k]));
        end
      end
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      reset  = ($urandom_range(0, 49) != 0);
      trig   = 3'($urandom);
      clr    = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
      req    = 1'($urandom);
      atomic = 1'($urandom);
      sel    = 2'($urandom);
      word   = 2'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (ack_o[k] !== e_ack || cnt_o[k] !== 4'(e_cnt[k]) || ovf_o[k] !== e_ovf(k)) begin
          n_errs++;
          $display("FAIL random%0d dut%0d: ack=%b count=%h ovf=%b, expected ack=%b count=%h ovf=%b",
                   i, k, ack_o[k], cnt_o[k], ovf_o[k], e_ack, 4'(e_cnt[k]), e_ovf(k));
        end
      end
    end
    reset = 1'b1; req = 1'b0; trig = '0; clr = '0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_coherence();
    test_wrap_sat();
    test_clr_trig_read();
    test_back_to_back();
    test_out_of_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
